instr_decode_stage: RTL and testbench

//  Registered decode stage between fetch and execute of the ball-balancer CPU.

---
 rtl/cpu_isa_pkg.sv | 72 +++++++
 rtl/instr_decode_stage_if.sv | 38 +++
 rtl/instr_decode_stage_decoder.sv | 73 +++++++
 rtl/instr_decode_stage.sv | 65 ++++++
 tb/tb_instr_decode_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_isa_pkg.sv
// Purpose: shared ISA definitions for the ball-balancer CPU (opcodes, ext codes, ALU ops).
// Contents: INSTR_W, opcode/ext constants, alu_op_e, decode_ctrl_t bundle, code->ALU helpers.
// Used by the decoder, the decode stage register and its interface.
package cpu_isa_pkg;

  localparam int INSTR_W = 16;

  // Major opcodes that are not immediate ALU ops
  localparam logic [3:0] OP_RR  = 4'b0000;
  localparam logic [3:0] OP_MEM = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b1111;

  // ALU codes: used as ext field for RR ops and as the opcode for immediate ops
  localparam logic [3:0] CODE_ADD = 4'b0101;
  localparam logic [3:0] CODE_SUB = 4'b1001;
  localparam logic [3:0] CODE_CMP = 4'b1011;
  localparam logic [3:0] CODE_AND = 4'b0001;
  localparam logic [3:0] CODE_OR  = 4'b0010;
  localparam logic [3:0] CODE_XOR = 4'b0011;
  localparam logic [3:0] CODE_MOV = 4'b1101;

  // Memory ext codes under OP_MEM
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_CMP  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_MOV  = 4'd7,
    ALU_LOAD = 4'd8,
    ALU_STOR = 4'd9
  } alu_op_e;

  // Decoded control bundle; the immediate travels separately because its width is a parameter
  typedef struct packed {
    logic    imm_ctrl;
    logic [3:0] rdest;
    logic [3:0] rsrc;
    alu_op_e alu_op;
    logic    reg_we;
    logic    illegal;
  } decode_ctrl_t;

  localparam decode_ctrl_t DECODE_CTRL_RESET = '{
    imm_ctrl: 1'b0, rdest: 4'd0, rsrc: 4'd0, alu_op: ALU_NOP, reg_we: 1'b0, illegal: 1'b0
  };

  // Maps a shared ALU code to its operation; ALU_NOP marks an unused code
  function automatic alu_op_e code_to_alu(input logic [3:0] code);
    case (code)
      CODE_ADD: code_to_alu = ALU_ADD;
      CODE_SUB: code_to_alu = ALU_SUB;
      CODE_CMP: code_to_alu = ALU_CMP;
      CODE_AND: code_to_alu = ALU_AND;
      CODE_OR:  code_to_alu = ALU_OR;
      CODE_XOR: code_to_alu = ALU_XOR;
      CODE_MOV: code_to_alu = ALU_MOV;
      default:  code_to_alu = ALU_NOP;
    endcase
  endfunction

  // Arithmetic immediates are signed; logical and move immediates are unsigned
  function automatic logic imm_is_signed(input alu_op_e op);
    imm_is_signed = (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_CMP);
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Purpose: fetch-side and execute-side handshake/bundle signals of the decode stage.
// Ports: slave = decode stage view (consumes instr, produces bundle);
//        master = environment view (fetch drives instr/flush, execute drives out_ready).
interface instr_decode_stage_if
  import cpu_isa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) ();

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic               imm_ctrl;
  logic [DATA_W-1:0]  immediate;
  logic [3:0]         rdest;
  logic [3:0]         rsrc;
  alu_op_e            alu_op;
  logic               reg_we;
  logic               illegal;
  logic [CNT_W-1:0]   illegal_cnt;

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, imm_ctrl, immediate, rdest, rsrc, alu_op, reg_we,
           illegal, illegal_cnt
  );

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, imm_ctrl, immediate, rdest, rsrc, alu_op, reg_we,
           illegal, illegal_cnt
  );

endinterface

// File: rtl/instr_decode_stage_decoder.sv
// Purpose: combinational 16-bit instruction decoder (instr -> control bundle + immediate).
// Latency: 0 cycles, purely combinational; no handshake of its own.
// Ports: instr in; ctrl (decode_ctrl_t) and immediate (DATA_W) out.
module instr_decoder
  import cpu_isa_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  output decode_ctrl_t       ctrl,
  output logic [DATA_W-1:0]  immediate
);

  logic [3:0]        op;
  logic [3:0]        ext;
  logic [7:0]        imm8;
  logic signed [7:0] imm8_s;
  alu_op_e           rr_alu;
  alu_op_e           imm_alu;

  assign op      = instr[15:12];
  assign ext     = instr[7:4];
  assign imm8    = instr[7:0];
  assign imm8_s  = instr[7:0];
  assign rr_alu  = code_to_alu(ext);
  assign imm_alu = code_to_alu(op);

  always_comb begin
    ctrl          = DECODE_CTRL_RESET;
    ctrl.rdest    = instr[11:8];
    ctrl.rsrc     = instr[3:0];
    immediate     = '0;

    case (op)
      OP_RR: begin
        if (rr_alu == ALU_NOP) begin
          ctrl.illegal = 1'b1;
        end else begin
          ctrl.alu_op = rr_alu;
          ctrl.reg_we = (rr_alu != ALU_CMP);
        end
      end
      OP_MEM: begin
        if (ext == EXT_LOAD) begin
          ctrl.alu_op = ALU_LOAD;
          ctrl.reg_we = 1'b1;
        end else if (ext == EXT_STOR) begin
          ctrl.alu_op = ALU_STOR;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        ctrl.imm_ctrl = 1'b1;
        ctrl.alu_op   = ALU_MOV;
        ctrl.reg_we   = 1'b1;
        immediate     = DATA_W'({imm8, 8'h00});
      end
      default: begin
        // Remaining opcodes reuse the RR ext encoding as immediate ALU ops
        if (imm_alu == ALU_NOP) begin
          ctrl.illegal = 1'b1;
        end else begin
          ctrl.imm_ctrl = 1'b1;
          ctrl.alu_op   = imm_alu;
          ctrl.reg_we   = (imm_alu != ALU_CMP);
          immediate     = imm_is_signed(imm_alu) ? DATA_W'(imm8_s) : DATA_W'(imm8);
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Purpose: registered decode stage between fetch and execute; holds one decoded bundle.
// Latency: 1 cycle from accept to out_valid; illegal_cnt updates with the same edge.
// Backpressure: in_ready = !out_valid | out_ready; flush drops held and incoming instr.
// Ports: clk, reset (sync, active-high), bus (instr_decode_stage_if.slave).
module instr_decode_stage
  import cpu_isa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_decode_stage_if.slave   bus
);

  decode_ctrl_t      dec_ctrl;
  logic [DATA_W-1:0] dec_imm;
  decode_ctrl_t      ctrl_q;
  logic [DATA_W-1:0] imm_q;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;

  instr_decoder #(.DATA_W(DATA_W)) u_decoder (
    .instr     (bus.instr),
    .ctrl      (dec_ctrl),
    .immediate (dec_imm)
  );

  assign bus.in_ready = !valid_q || bus.out_ready;
  // A flushed cycle never loads, so the incoming instr is neither decoded nor counted
  assign accept = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= DECODE_CTRL_RESET;
      imm_q   <= '0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_ctrl;
      imm_q   <= dec_imm;
      if (dec_ctrl.illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (bus.out_ready) begin
      // Consumed with nothing new: only valid drops, payload keeps its last value
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.imm_ctrl    = ctrl_q.imm_ctrl;
  assign bus.immediate   = imm_q;
  assign bus.rdest       = ctrl_q.rdest;
  assign bus.rsrc        = ctrl_q.rsrc;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.reg_we      = ctrl_q.reg_we;
  assign bus.illegal     = ctrl_q.illegal;
  assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;
  import cpu_isa_pkg::*;

  localparam int DW = 16;
  localparam int CW = 8;

  typedef struct {
    int imm_ctrl;
    int immediate;
    int rdest;
    int rsrc;
    int alu;
    int reg_we;
    int illegal;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_decode_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  instr_decode_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   model_cnt = 0;
  bit   mon_en = 1'b0;
  int   alu_of[16];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules, using plain integers
  function automatic exp_t model(input logic [15:0] i);
    exp_t e;
    int op, ext, imm;
    op  = int'(i[15:12]);
    ext = int'(i[7:4]);
    imm = int'(i[7:0]);
    e = '{imm_ctrl: 0, immediate: 0, rdest: int'(i[11:8]), rsrc: int'(i[3:0]),
          alu: int'(ALU_NOP), reg_we: 0, illegal: 0};
    if (op == 0) begin
      if (alu_of[ext] >= 0) begin
        e.alu = alu_of[ext];
        e.reg_we = (e.alu != int'(ALU_CMP));
      end else e.illegal = 1;
    end else if (op == 4) begin
      if (ext == 0) begin e.alu = int'(ALU_LOAD); e.reg_we = 1; end
      else if (ext == 4) e.alu = int'(ALU_STOR);
      else e.illegal = 1;
    end else if (op == 15) begin
      e.imm_ctrl = 1; e.alu = int'(ALU_MOV); e.reg_we = 1; e.immediate = imm * 256;
    end else if (alu_of[op] >= 0) begin
      e.imm_ctrl = 1;
      e.alu = alu_of[op];
      e.reg_we = (e.alu != int'(ALU_CMP));
      if ((e.alu == int'(ALU_ADD) || e.alu == int'(ALU_SUB) || e.alu == int'(ALU_CMP)) && imm >= 128)
        e.immediate = imm - 256 + 65536;
      else
        e.immediate = imm;
    end else e.illegal = 1;
    return e;
  endfunction

  // Monitor/scoreboard: inputs change #1 after posedge, so the negedge sees what the next edge will use
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", bus.in_ready, (!bus.out_valid || bus.out_ready));
      chk("out_valid", bus.out_valid, sb_q.size() > 0);
      chk("illegal_cnt", bus.illegal_cnt, model_cnt);
      if (bus.out_valid && sb_q.size() > 0) begin
        chk("imm_ctrl", bus.imm_ctrl, sb_q[0].imm_ctrl);
        chk("immediate", bus.immediate, sb_q[0].immediate);
        chk("rdest", bus.rdest, sb_q[0].rdest);
        chk("rsrc", bus.rsrc, sb_q[0].rsrc);
        chk("alu_op", int'(bus.alu_op), sb_q[0].alu);
        chk("reg_we", bus.reg_we, sb_q[0].reg_we);
        chk("illegal", bus.illegal, sb_q[0].illegal);
      end
      if (bus.flush) begin
        sb_q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
        if (bus.in_valid && bus.in_ready) begin
          exp_t e;
          e = model(bus.instr);
          sb_q.push_back(e);
          if (e.illegal != 0 && model_cnt < 255) model_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] ins);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for instr 0x%0h", ins);
    end
  endtask

  task automatic idle(input int cycles, input logic rdy);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = rdy;
    repeat (cycles - 1) @(posedge clk);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    logic [3:0]  codes [8];
    codes = '{CODE_ADD, CODE_SUB, CODE_CMP, CODE_AND, CODE_OR, CODE_XOR, CODE_MOV, OP_LUI};
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0: r[15:12] = 4'h0;
      1: r[15:12] = codes[$urandom_range(0, 7)];
      2: begin r[15:12] = 4'h0; r[7:4] = codes[$urandom_range(0, 6)]; end
      3: begin r[15:12] = OP_MEM; r[7:4] = ($urandom_range(0, 1) != 0) ? EXT_LOAD : EXT_STOR; end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [15:0] directed [6];
    for (int c = 0; c < 16; c++) alu_of[c] = -1;
    alu_of[5]  = int'(ALU_ADD);  alu_of[9]  = int'(ALU_SUB);  alu_of[11] = int'(ALU_CMP);
    alu_of[1]  = int'(ALU_AND);  alu_of[2]  = int'(ALU_OR);   alu_of[3]  = int'(ALU_XOR);
    alu_of[13] = int'(ALU_MOV);

    bus.in_valid = 1'b0; bus.instr = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_immediate", bus.immediate, 0);
    chk("rst_alu_op", int'(bus.alu_op), int'(ALU_NOP));
    chk("rst_regs", {bus.rdest, bus.rsrc, bus.imm_ctrl, bus.reg_we, bus.illegal}, 0);
    chk("rst_cnt", bus.illegal_cnt, 0);
    mon_en = 1'b1;

    // Directed: ADDI, ANDI, LUI, ADD rr, CMP rr, OR rr
    directed = '{16'h53F0, 16'h1280, 16'hF5AB, 16'h0257, 16'h02B1, 16'h0B21};
    foreach (directed[k]) send(directed[k]);
    idle(3, 1'b1);

    // Backpressure: hold A for 3 cycles while B waits, then a single consume
    send(16'h9A81);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.instr     = 16'h0357;
    repeat (3) begin
      @(negedge clk);
      chk("hold_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    idle(3, 1'b1);

    // Flush while holding, with an illegal instr offered in the same cycle
    send(16'h0257);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.instr     = 16'h7000;
    bus.flush     = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_cnt", bus.illegal_cnt, 0);
    idle(3, 1'b1);

    // Randomized traffic with backpressure and occasional flushes
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.instr     = rand_instr();
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.out_ready = bus.flush ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
    idle(3, 1'b1);

    // Saturation of the illegal counter
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.instr    = 16'h7000;
    repeat (260) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", bus.illegal_cnt, 255);
    chk("sat_illegal", bus.illegal, 1);
    chk("sat_alu_op", int'(bus.alu_op), int'(ALU_NOP));
    chk("drain_empty", sb_q.size(), 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
